// File: rtl/wb_refill_buffer.sv
// wb_refill_buffer
// Write-back buffer that sits between a cache and DRAM. Dirty evictions are
// queued in a small circular FIFO and drained to memory when the memory port
// is otherwise idle. Refill reads are forwarded from the buffer when the
// address is still pending there; otherwise they are issued to DRAM.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module wb_refill_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_full,
    output logic                  wb_empty,
    output logic                  wb_ovf,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    // Address of the outstanding DRAM refill, held stable for the transaction
    logic [ADDR_WIDTH-1:0] req_addr;

    // Decoded control
    logic                  full;
    logic                  empty;
    logic                  enq_ok;
    logic                  enq_new;
    logic                  pop;

    // Coalescing search results
    logic                  co_hit;
    logic [PTR_W-1:0]      co_idx;
    logic [PTR_W-1:0]      co_scan;

    // Read-forwarding search results
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_hit_data;
    logic [PTR_W-1:0]      rd_scan;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wb_full  = full;
    assign wb_empty = empty;

    // A full buffer drops the write even if the head pops this same cycle
    assign enq_ok  = wb_en && !full;
    assign enq_new = enq_ok && !co_hit;
    assign pop     = (state == DRAIN) && mem_ack;

    // Find the youngest buffered entry with the incoming eviction address, skipping a head that is being written out
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        co_scan = '0;
        for (int k = 0; k < DEPTH; k++) begin
            co_scan = head + PTR_W'(k);
            if (valid_q[co_scan] && (addr_q[co_scan] == wb_addr) &&
                !((state == DRAIN) && (co_scan == head))) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end

    // Find the youngest data for the refill address; a same-cycle eviction of that address is newest of all
    always_comb begin
        rd_hit      = 1'b0;
        rd_hit_data = '0;
        rd_scan     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_scan = head + PTR_W'(k);
            if (valid_q[rd_scan] && (addr_q[rd_scan] == rd_addr)) begin
                rd_hit      = 1'b1;
                rd_hit_data = data_q[rd_scan];
            end
        end
        if (enq_ok && (wb_addr == rd_addr)) begin
            rd_hit      = 1'b1;
            rd_hit_data = wb_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: reads win over draining unless the buffer is full
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (full) begin
                    next_state = DRAIN;
                end else if (rd_req) begin
                    next_state = rd_hit ? RESP : READ;
                end else if (!empty) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            READ: begin
                if (mem_ack) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: memory port is driven only while a transaction is open, so reset drops it at once
    always_comb begin
        rd_valid  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q[head];
                mem_wdata = data_q[head];
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
            end
            RESP: begin
                rd_valid = 1'b1;
            end
            default: begin
                rd_valid = 1'b0;
            end
        endcase
    end

    // Entry payload: coalesce into a matching entry or allocate at the tail
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            if (co_hit) begin
                data_q[co_idx] <= wb_data;
            end else begin
                addr_q[tail] <= wb_addr;
                data_q[tail] <= wb_data;
            end
        end
    end

    // Pointers, occupancy, valid bits and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            wb_ovf  <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (enq_new) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            case ({enq_new, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wb_en && full) begin
                wb_ovf <= 1'b1;
            end
        end
    end

    // Capture refill address on a miss and response data on a hit or DRAM completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            req_addr <= '0;
        end else begin
            if ((state == IDLE) && (next_state == RESP)) begin
                rd_data <= rd_hit_data;
            end
            if ((state == IDLE) && (next_state == READ)) begin
                req_addr <= rd_addr;
            end
            if ((state == READ) && mem_ack) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule
